block_pipe_sequencer: RTL and testbench

Parametrised frame sequencer for the block-transform pipeline (source SRAM -> DCT passes -> transpose / zigzag ping-pong buffers -> sink SRAM).
- Replaces the free-running saturating counters and the per-stage ping-pong toggle logic.
- Uses one master position counter with per-stage offsets, a start/done handshake, stall support and an explicit frame length.
- Gives each stage a row index, a valid flag, a ping-pong bank select and a row address.

---
 rtl/block_pipe_sequencer.sv | 111 +++++++++++
 tb/tb_block_pipe_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/block_pipe_sequencer.sv
// rtl/block_pipe_sequencer.sv - frame sequencer for the block-transform pipeline
module block_pipe_sequencer #(
    parameter int ADDR_W   = 15,
    parameter int LOG2_BLK = 3,
    parameter int NSTG     = 3,
    parameter int OFS_W    = 8,
    parameter logic [NSTG*OFS_W-1:0] STAGE_OFS = {8'd27, 8'd18, 8'd9}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        num_rows_i,
    input  logic                     stall_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_valid_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    output logic [NSTG-1:0]          stg_valid_o,
    output logic [NSTG*LOG2_BLK-1:0] stg_row_o,
    output logic [NSTG-1:0]          stg_sel_o,
    output logic [ADDR_W-1:0]        wr_addr_o
);

    // One extra bit so that num_rows-1 plus the sink offset never wraps.
    localparam int PW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       p_q;
    logic [ADDR_W-1:0]   len_q;
    logic [PW-1:0]       len_ext;
    logic [PW-1:0]       last_w;

    function automatic logic [PW-1:0] stage_ofs(input int s);
        return {{(PW-OFS_W){1'b0}}, STAGE_OFS[s*OFS_W +: OFS_W]};
    endfunction

    assign len_ext = {1'b0, len_q};
    assign last_w  = len_ext - PW'(1) + stage_ofs(NSTG-1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q   <= num_rows_i;
                        p_q     <= '0;
                        state_q <= (num_rows_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall_i) begin
                        if (p_q == last_w) begin
                            state_q <= S_DONE;
                        end else begin
                            p_q <= p_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

    logic          run;
    logic [PW-1:0] c;
    logic          v;

    always_comb begin
        run         = (state_q == S_RUN);
        rd_valid_o  = run && (p_q < len_ext);
        rd_addr_o   = rd_valid_o ? p_q[ADDR_W-1:0] : '0;
        stg_valid_o = '0;
        stg_row_o   = '0;
        stg_sel_o   = '0;
        wr_addr_o   = '0;
        c           = '0;
        v           = 1'b0;
        // Each stage trails the master position by its own offset.
        for (int s = 0; s < NSTG; s++) begin
            c = p_q - stage_ofs(s);
            v = run && (p_q >= stage_ofs(s)) && (c < len_ext);
            stg_valid_o[s] = v;
            if (v) begin
                stg_row_o[s*LOG2_BLK +: LOG2_BLK] = c[LOG2_BLK-1:0];
                stg_sel_o[s] = ~c[LOG2_BLK];
                if (s == NSTG - 1) begin
                    wr_addr_o = c[ADDR_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_block_pipe_sequencer.sv
// tb/tb_block_pipe_sequencer.sv - directed bench for block_pipe_sequencer
module tb_block_pipe_sequencer;

    localparam int ADDR_W = 15;
    localparam int O0 = 9, O1 = 18, O2 = 27;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [ADDR_W-1:0] num_rows_i;
    logic              stall_i;
    logic              busy_o, done_o, rd_valid_o;
    logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
    logic [2:0]        stg_valid_o, stg_sel_o;
    logic [8:0]        stg_row_o;

    int errors = 0;
    int checks = 0;

    block_pipe_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .stall_i     (stall_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_valid_o  (rd_valid_o),
        .rd_addr_o   (rd_addr_o),
        .stg_valid_o (stg_valid_o),
        .stg_row_o   (stg_row_o),
        .stg_sel_o   (stg_sel_o),
        .wr_addr_o   (wr_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {busy_o, done_o, rd_valid_o, rd_addr_o, stg_valid_o, stg_sel_o}, 32'd0);
        chk({tag, "_rows"}, {stg_row_o, wr_addr_o}, 32'd0);
    endtask

    // Runs one frame from IDLE, checking every output each cycle against a
    // row/offset model, then the done edge and the busy fall edge.
    task automatic run_frame(input int len, input int stall_p, input int stall_n,
                             input int extra_start, input int exp_done_edge);
        int st, pos, left, done_edge, idle_edge, c, ndone;
        logic [2:0] ev, es;
        logic [8:0] er;
        logic [31:0] ewr;
        logic stl;
        num_rows_i = ADDR_W'(len);
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        num_rows_i = '0;
        st = (len == 0) ? 2 : 1;
        pos = 0; left = stall_n; done_edge = -1; idle_edge = -1; ndone = 0;
        for (int n = 1; n < 200; n++) begin
            ev = '0; es = '0; er = '0; ewr = 0;
            for (int s = 0; s < 3; s++) begin
                int o;
                o = (s == 0) ? O0 : (s == 1) ? O1 : O2;
                c = pos - o;
                if (st == 1 && pos >= o && c < len) begin
                    ev[s] = 1'b1;
                    er[s*3 +: 3] = 3'(c % 8);
                    es[s] = ((c / 8) % 2) == 0;
                    if (s == 2) ewr = 32'(c);
                end
            end
            chk("busy", {31'd0, busy_o}, {31'd0, st != 0});
            chk("done", {31'd0, done_o}, {31'd0, st == 2});
            chk("rd_valid", {31'd0, rd_valid_o}, {31'd0, st == 1 && pos < len});
            chk("rd_addr", {17'd0, rd_addr_o}, (st == 1 && pos < len) ? 32'(pos) : 32'd0);
            chk("stg_valid", {29'd0, stg_valid_o}, {29'd0, ev});
            chk("stg_row", {23'd0, stg_row_o}, {23'd0, er});
            chk("stg_sel", {29'd0, stg_sel_o}, {29'd0, es});
            chk("wr_addr", {17'd0, wr_addr_o}, ewr);
            if (done_o) begin
                ndone++;
                if (done_edge < 0) done_edge = n;
            end
            if (!busy_o && idle_edge < 0) idle_edge = n;
            if (st == 0) break;
            stl = (st == 1 && pos == stall_p && left > 0);
            if (stl) left--;
            stall_i = stl;
            start_i = (n == extra_start) || (st == 2 && extra_start > 0);
            num_rows_i = start_i ? ADDR_W'(5) : '0;
            tick();
            stall_i = 1'b0;
            start_i = 1'b0;
            num_rows_i = '0;
            if (st == 2) st = 0;
            else if (st == 1 && !stl) begin
                if (pos == len - 1 + O2) st = 2;
                else pos++;
            end
        end
        chk("done_edge", 32'(done_edge), 32'(exp_done_edge));
        chk("idle_edge", 32'(idle_edge), 32'(exp_done_edge + 1));
        chk("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        reset = 1'b0; start_i = 1'b1; stall_i = 1'b0; num_rows_i = ADDR_W'(16);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("reset");
        end
        reset = 1'b1; start_i = 1'b0; num_rows_i = '0;
        tick();
        chk_all_zero("idle");

        run_frame(16, -1, 0, 0, 44);
        run_frame(16, 5, 3, 0, 47);
        run_frame(0, -1, 0, 0, 1);
        run_frame(11, -1, 0, 0, 39);
        run_frame(16, -1, 0, 20, 44);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_restart", {31'd0, busy_o}, 32'd0);
        end

        num_rows_i = ADDR_W'(16);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        num_rows_i = '0;
        for (int i = 2; i < 30; i++) tick();
        chk("midframe_busy", {31'd0, busy_o}, 32'd1);
        reset = 1'b0;
        tick();
        chk_all_zero("abort");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_quiet", {30'd0, busy_o, done_o}, 32'd0);
        end
        run_frame(8, -1, 0, 0, 36);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
